// File: rtl/uart_pkg.sv
// Shared definitions for the serial receiver.
//   uart_rx_state_t      : receiver FSM states
//   PLL_CLOCK_RATE       : system clock frequency in Hz
//   SER_CLOCK_RATE       : serial baud rate
//   DEFAULT_CLKS_PER_BIT : clock cycles per serial bit at those rates
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_rx_state_t;

   localparam int PLL_CLOCK_RATE       = 24000000;
   localparam int SER_CLOCK_RATE       = 1200;
   localparam int DEFAULT_CLKS_PER_BIT = PLL_CLOCK_RATE / SER_CLOCK_RATE;

endpackage

// File: rtl/uart_rx_if.sv
// Byte output channel of the serial receiver (one-entry valid/ready).
//   o_data  : received byte, meaningful while o_valid is high
//   o_valid : holding register is full
//   i_ready : consumer takes the byte when o_valid && i_ready
// master = receiver side, slave = byte consumer side.
interface uart_rx_if;

   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;

   modport master (
      output o_data,
      output o_valid,
      input  i_ready
   );

   modport slave (
      input  o_data,
      input  o_valid,
      output i_ready
   );

endinterface

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs.
//   clock : destination clock
//   reset : synchronous active-high reset, loads RESET_VAL into both stages
//   d     : asynchronous input bits
//   q     : synchronised bits, two clock cycles behind d
// Each bit gets its own independent flop pair, so the same block serves the
// serial data line as well as slow handshake pins such as DTR/RTS.
module sync2 #(
   parameter int   WIDTH     = 1,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clock) begin
            if (reset) begin
               meta_reg <= RESET_VAL;
               sync_reg <= RESET_VAL;
            end else begin
               meta_reg <= d[gi];
               sync_reg <= meta_reg;
            end
         end

         assign q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver.
//   clock       : system clock, rising edge
//   reset       : synchronous active-high reset
//   ser_rx      : raw asynchronous serial line, idle high
//   rx          : byte output channel (o_data / o_valid / i_ready)
//   o_frame_err : one-cycle pulse when the stop bit is sampled low
//   o_overrun   : sticky flag, a completed byte was dropped because the
//                 holding register was still full; cleared only by reset
//   o_busy      : high whenever a frame is being received
// A falling edge on the synchronised line starts a frame; the start bit is
// re-checked at its midpoint and every following bit is sampled one bit
// period later, i.e. also at its midpoint.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     ser_rx,
   uart_rx_if.master rx,
   output logic     o_frame_err,
   output logic     o_overrun,
   output logic     o_busy
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   uart_rx_state_t state_reg;
   uart_rx_state_t state_next;

   logic             rx_sync;
   logic             rx_prev_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       bit_idx_reg;
   logic [7:0]       shift_reg;
   logic [7:0]       data_reg;
   logic             valid_reg;
   logic             frame_err_reg;
   logic             overrun_reg;

   // Decoded per-state events
   logic falling_edge;
   logic start_sample;
   logic data_sample;
   logic stop_sample;
   logic byte_done;
   logic handshake;

   sync2 #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (ser_rx),
      .q     (rx_sync)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (falling_edge) state_next = START;
         START: if (start_sample) state_next = rx_sync ? IDLE : DATA;
         DATA:  if (data_sample && (bit_idx_reg == 3'd7)) state_next = STOP;
         STOP:  if (stop_sample) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output / event decode
   always_comb begin
      falling_edge = 1'b0;
      start_sample = 1'b0;
      data_sample  = 1'b0;
      stop_sample  = 1'b0;
      o_busy       = (state_reg != IDLE);
      case (state_reg)
         IDLE:  falling_edge = rx_prev_reg & ~rx_sync;
         START: start_sample = (cnt_reg == HALF_LAST);
         DATA:  data_sample  = (cnt_reg == BIT_LAST);
         STOP:  stop_sample  = (cnt_reg == BIT_LAST);
         default: ;
      endcase
   end

   assign byte_done = stop_sample & rx_sync;
   assign handshake = valid_reg & rx.i_ready;

   // Datapath: sample counter, shift register, holding register and flags
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_prev_reg   <= 1'b1;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         rx_prev_reg   <= rx_sync;
         frame_err_reg <= 1'b0;

         // Counter restarts at every sample point so each bit period is
         // measured from the previous midpoint, independent of power-of-two C.
         if ((state_reg == IDLE) || start_sample || data_sample || stop_sample) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end

         if (start_sample) begin
            bit_idx_reg <= '0;
         end

         // LSB arrives first, so shifting right leaves bit 0 at position 0
         // once all eight bits are in.
         if (data_sample) begin
            shift_reg   <= {rx_sync, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
         end

         // A slot that is being emptied this cycle counts as free.
         if (byte_done && (!valid_reg || rx.i_ready)) begin
            data_reg  <= shift_reg;
            valid_reg <= 1'b1;
         end else if (byte_done) begin
            overrun_reg <= 1'b1;
         end else if (handshake) begin
            valid_reg <= 1'b0;
         end

         if (stop_sample && !rx_sync) begin
            frame_err_reg <= 1'b1;
         end
      end
   end

   assign rx.o_data   = data_reg;
   assign rx.o_valid  = valid_reg;
   assign o_frame_err = frame_err_reg;
   assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLKS_PER_BIT = 8.
// Expected bytes and frame errors are queued when a frame is sent; a
// separate monitor pops and compares them when the DUT presents them.
module tb_uart_rx;

   localparam int C   = 8;
   localparam int H   = C / 2;
   localparam int LAT = H + 9 * C + 3;   // pin edge to o_valid, in cycles

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic ser_rx = 1'b1;
   logic o_frame_err;
   logic o_overrun;
   logic o_busy;

   uart_rx_if u_if ();

   uart_rx #(
      .CLKS_PER_BIT (C)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ser_rx      (ser_rx),
      .rx          (u_if),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_busy      (o_busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] exp_data_q [$];
   int         exp_fe_cnt  = 0;
   logic       exp_overrun = 1'b0;

   // Observations collected by the monitor
   int         hs_cyc_q [$];
   int         fe_cyc_q [$];
   int         valid_hi_cnt     = 0;
   int         overrun_rise_cyc = -1;
   logic       prev_overrun     = 1'b0;
   logic [7:0] mon_exp;
   int         last_start = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Drives one 8N1 frame starting now; updates the reference model.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit track);
      last_start = cyc;
      if (track) begin
         if (!stop_bit) exp_fe_cnt++;
         else if (!u_if.i_ready && exp_data_q.size() > 0) exp_overrun = 1'b1;
         else exp_data_q.push_back(d);
      end
      $display("tx byte %02h stop=%0b at cycle %0d", d, stop_bit, cyc);
      ser_rx = 1'b0;
      wait_cycles(C);
      for (int i = 0; i < 8; i++) begin
         ser_rx = d[i];
         wait_cycles(C);
      end
      ser_rx = stop_bit;
      wait_cycles(C);
   endtask

   // Monitor / scoreboard
   always @(negedge clock) begin
      if (u_if.o_valid) valid_hi_cnt++;
      if (u_if.o_valid && u_if.i_ready) begin
         hs_cyc_q.push_back(cyc);
         checks++;
         if (exp_data_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got byte %02h want none (cycle %0d)", u_if.o_data, cyc);
         end else begin
            mon_exp = exp_data_q.pop_front();
            if (u_if.o_data !== mon_exp) begin
               errors++;
               $display("FAIL rx_data: got %02h want %02h (cycle %0d)", u_if.o_data, mon_exp, cyc);
            end else begin
               $display("rx byte %02h at cycle %0d", u_if.o_data, cyc);
            end
         end
      end
      if (o_frame_err) begin
         fe_cyc_q.push_back(cyc);
         checks++;
         if (exp_fe_cnt == 0) begin
            errors++;
            $display("FAIL frame_err_unexpected: got 1 want 0 (cycle %0d)", cyc);
         end else begin
            exp_fe_cnt--;
            $display("rx frame error at cycle %0d", cyc);
         end
      end
      if (o_overrun && !prev_overrun) overrun_rise_cyc = cyc;
      prev_overrun = o_overrun;
   end

   // Watchdog
   initial begin
      repeat (50000) @(posedge clock);
      $display("FAIL watchdog: got timeout want finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hs0, vh0, fe0, busy_cnt, start2, n;
      logic [7:0] rd;

      u_if.i_ready = 1'b1;
      reset = 1'b1;
      wait_cycles(3);
      check("reset_valid", u_if.o_valid, 0);
      check("reset_data", u_if.o_data, 0);
      check("reset_frame_err", o_frame_err, 0);
      check("reset_overrun", o_overrun, 0);
      check("reset_busy", o_busy, 0);
      reset = 1'b0;
      wait_cycles(3);

      // 1: single byte, latency and one-cycle valid
      hs0 = hs_cyc_q.size();
      vh0 = valid_hi_cnt;
      fe0 = fe_cyc_q.size();
      send_frame(8'hA5, 1'b1, 1);
      wait_cycles(4);
      check("t1_hs_count", hs_cyc_q.size() - hs0, 1);
      if (hs_cyc_q.size() > hs0) check("t1_latency", hs_cyc_q[hs_cyc_q.size()-1] - last_start, LAT);
      check("t1_valid_width", valid_hi_cnt - vh0, 1);
      check("t1_no_frame_err", fe_cyc_q.size() - fe0, 0);
      check("t1_overrun", o_overrun, exp_overrun);

      // 2: overrun with consumer stalled
      u_if.i_ready = 1'b0;
      send_frame(8'h3C, 1'b1, 1);
      send_frame(8'h81, 1'b1, 1);
      start2 = last_start;
      check("t2_valid", u_if.o_valid, 1);
      check("t2_data_kept", u_if.o_data, 8'h3C);
      check("t2_overrun", o_overrun, exp_overrun);
      check("t2_overrun_cycle", overrun_rise_cyc - start2, LAT);
      hs0 = hs_cyc_q.size();
      u_if.i_ready = 1'b1;
      n = 0;
      while (u_if.o_valid && n < 10) begin
         wait_cycles(1);
         n++;
      end
      check("t2_valid_drop_timeout", (n < 10), 1);
      wait_cycles(3);
      check("t2_valid_low", u_if.o_valid, 0);
      check("t2_one_transfer", hs_cyc_q.size() - hs0, 1);

      // 3: framing error, long break, recovery
      fe0 = fe_cyc_q.size();
      vh0 = valid_hi_cnt;
      send_frame(8'h55, 1'b0, 1);
      check("t3_fe_count", fe_cyc_q.size() - fe0, 1);
      if (fe_cyc_q.size() > fe0) check("t3_fe_cycle", fe_cyc_q[fe_cyc_q.size()-1] - last_start, LAT);
      busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         wait_cycles(1);
         if (o_busy) busy_cnt++;
      end
      check("t3_no_retrigger", busy_cnt, 0);
      check("t3_no_valid", valid_hi_cnt - vh0, 0);
      ser_rx = 1'b1;
      wait_cycles(10);
      hs0 = hs_cyc_q.size();
      send_frame(8'h12, 1'b1, 1);
      wait_cycles(4);
      check("t3_recover_hs", hs_cyc_q.size() - hs0, 1);
      check("t3_recover_no_fe", fe_cyc_q.size() - fe0, 1);

      // 4: short glitch is a false start
      vh0 = valid_hi_cnt;
      fe0 = fe_cyc_q.size();
      ser_rx = 1'b0;
      wait_cycles(2);
      ser_rx = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         wait_cycles(1);
         if (o_busy) busy_cnt++;
      end
      check("t4_busy_bounded", (busy_cnt >= 1 && busy_cnt <= H), 1);
      check("t4_no_valid", valid_hi_cnt - vh0, 0);
      check("t4_no_fe", fe_cyc_q.size() - fe0, 0);
      check("t4_overrun", o_overrun, exp_overrun);

      // 5: reset during data bit 4
      fork
         send_frame(8'hF0, 1'b1, 0);
         begin
            wait_cycles(4 * C + C + 3);
            reset = 1'b1;
            wait_cycles(1);
            reset = 1'b0;
            exp_overrun = 1'b0;
            check("t5_valid", u_if.o_valid, 0);
            check("t5_data", u_if.o_data, 0);
            check("t5_frame_err", o_frame_err, 0);
            check("t5_overrun", o_overrun, 0);
            check("t5_busy", o_busy, 0);
         end
      join
      wait_cycles(5);
      hs0 = hs_cyc_q.size();
      send_frame(8'hFF, 1'b1, 1);
      wait_cycles(4);
      check("t5_after_reset_hs", hs_cyc_q.size() - hs0, 1);

      // 6: back-to-back frames
      hs0 = hs_cyc_q.size();
      send_frame(8'h00, 1'b1, 1);
      send_frame(8'hFF, 1'b1, 1);
      wait_cycles(4);
      check("t6_hs_count", hs_cyc_q.size() - hs0, 2);
      if (hs_cyc_q.size() >= hs0 + 2)
         check("t6_spacing", hs_cyc_q[hs0+1] - hs_cyc_q[hs0], 10 * C);

      // Random bytes with random idle gaps
      for (int k = 0; k < 8; k++) begin
         rd = 8'($urandom);
         wait_cycles($urandom_range(0, 5));
         hs0 = hs_cyc_q.size();
         send_frame(rd, 1'b1, 1);
         wait_cycles(3);
         check("rand_hs_count", hs_cyc_q.size() - hs0, 1);
         if (hs_cyc_q.size() > hs0) check("rand_latency", hs_cyc_q[hs_cyc_q.size()-1] - last_start, LAT);
      end

      wait_cycles(10);
      check("end_bytes_pending", exp_data_q.size(), 0);
      check("end_fe_pending", exp_fe_cnt, 0);
      check("end_overrun", o_overrun, exp_overrun);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
